hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard, forwarding and writeback-tracking unit for the 8-bit pipelined processor. It sits beside the ID stage and tracks in-flight destination registers in a shift history. It produces forwarding selects for EX, load-use stalls, branch flush windows and the register-file write enable/address. Depth, load latency and flush width are parameters, which replaces per-opcode hand-coded bypass logic.

## Interface
- FWD_DEPTH, 2, in-flight slots tracked and forwardable (1..4); slot 1 = youngest
- LOAD_STALL, 1, a load in slot k with k <= LOAD_STALL blocks a dependent issue (0..3)
- FLUSH_DEPTH, 2, cycles of issue suppression per taken branch (1..4)
- FS_W, $clog2(FWD_DEPTH+1), derived, select width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_instr  in  8  ID instruction; [3:0] opcode, [7:6] R1, [5:4] R2
- ex_hold  in  1  external freeze (memory wait)
- branch_taken  in  1  EX resolved a taken branch
- issue  out  1  ID instruction advances this cycle (comb)
- stall  out  1  hold PC and IF/ID (comb)
- flush  out  1  kill IF/ID contents (comb)
- fwd_a_sel, fwd_b_sel  out  FS_W  EX operand source: 0 = RF, k = slot k result (registered)
- rf_write  out  1  oldest slot writes RF this cycle (registered)
- rf_waddr  out  2  its destination (registered)

## Operation
- Decode: writers are add 0100, sub 0110, nand 1000, shift x011, ori x111, load 0000. Destination is [7:6]; ori destination is fixed r1.
- Decode sources:
  - add, sub, nand, load, store read R1 and R2.
  - shift reads R1.
  - ori reads r1.
  - Branches 0101/1101/1001 and nop read none.
- History: FWD_DEPTH entries {valid, dst, is_load}. It shifts one slot per non-held cycle. Slot 1 gets the decoded ID entry on issue and a bubble (valid=0) otherwise.
- Forward select per source: the lowest k whose valid entry has a matching dst. If none matches, 0.
- hazard = an id_valid source matches a valid load in slot k <= LOAD_STALL.
- flush_cnt: loaded with FLUSH_DEPTH-1 when branch_taken is high. While nonzero it decrements each non-held cycle.
- flush = ~ex_hold & (branch_taken | flush_cnt != 0).
- stall = ~ex_hold & ~flush & id_valid & hazard.
- issue = ~ex_hold & ~flush & id_valid & ~hazard.
- fwd_a_sel/fwd_b_sel load the computed selects on issue. They load 0 on a pushed bubble and hold under ex_hold.
- rf_write/rf_waddr come from the entry leaving slot FWD_DEPTH. RF has no write-through, so slot FWD_DEPTH remains forwardable.

## Timing
- Reset values: history invalid, flush_cnt 0, fwd sels 0, rf_write 0, rf_waddr 0. While reset is high, issue, stall and flush are 0.
- Forward-select latency: one cycle (select valid while the instruction is in EX).
- Load-use penalty: max(0, LOAD_STALL - k + 1) bubbles for a dependency at distance k.
- Priority: reset > ex_hold > branch_taken > hazard.
- ex_hold freezes history, flush_cnt and registered outputs. branch_taken is ignored under hold because EX re-presents it.
- A branch_taken during a nonzero flush_cnt reloads the counter.
- A hazard during a flush window produces no stall, because flush already suppresses issue.
- Register r0 is tracked like any other register; there is no hardwired zero.
- Reset mid-stall or mid-flush clears everything; the first cycle after reset has no forwarding.

## Structure
- isa_pkg:
  - opcode constants
  - ORI_DST = 2'd1
  - history entry struct {valid, dst, is_load}
  - decode function returning {writes, dst, rd_a, rd_b, src_a, src_b, is_load}
- Sub-module instr_decode (combinational, wraps the package function) is instantiated once for id_instr. hazard_ctrl holds the history, the counter and the select comparators.

## Test plan
- Defaults; 8'h64 (add r1,r2) then 8'h76 (sub r1,r3) -> second issue unstalled; next cycle fwd_a_sel=1, fwd_b_sel=0.
- 8'hB0 (load r2) then 8'h24 (add r0,r2) -> stall=1 one cycle, issue=0; next cycle issue=1; then fwd_b_sel=2.
- LOAD_STALL=0, same sequence -> no stall, fwd_b_sel=1.
- 8'h1F (ori 3) then 8'h54 (add r1,r1) -> fwd_a_sel=1, fwd_b_sel=1; ori reaches slot 2 -> rf_write=1, rf_waddr=1.
- branch_taken one cycle with FLUSH_DEPTH=2 -> flush=1 two cycles, issue=0; rf_write stays 0 for both bubbles after they drain.
- ex_hold=1 for 3 cycles during a load-use stall -> stall=0, outputs frozen; after release the stall completes with one bubble. Reset asserted mid-flush -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: ISA opcodes, history entry and decode types plus the decode function
// Shared by instr_decode and hazard_ctrl; no ports.
package hazard_ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BR0   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BR1   = 4'b1001;
    localparam logic [3:0] OP_BR2   = 4'b1101;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_ORI   = 3'b111;

    localparam logic [1:0] ORI_DST = 2'd1;

    typedef struct packed {
        logic       valid;
        logic [1:0] dst;
        logic       is_load;
    } hist_entry_t;

    typedef struct packed {
        logic       writes;
        logic [1:0] dst;
        logic       rd_a;
        logic       rd_b;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       is_load;
    } decode_t;

    // Branches and every unlisted opcode behave as nops: no source, no destination.
    function automatic decode_t decode(input logic [7:0] instr);
        decode_t    d;
        logic [3:0] op;
        logic       rr, sh, ori;
        op  = instr[3:0];
        rr  = op == OP_ADD || op == OP_SUB || op == OP_NAND || op == OP_LOAD || op == OP_STORE;
        sh  = op[2:0] == OP_SHIFT;
        ori = op[2:0] == OP_ORI;
        d.writes  = (rr && op != OP_STORE) || sh || ori;
        d.dst     = ori ? ORI_DST : instr[7:6];
        d.rd_a    = rr || sh || ori;
        d.rd_b    = rr;
        d.src_a   = ori ? ORI_DST : instr[7:6];
        d.src_b   = instr[5:4];
        d.is_load = op == OP_LOAD;
        return d;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX-side signals of the hazard unit
// master = pipeline (drives id_valid, id_instr, ex_hold, branch_taken)
// slave  = hazard_ctrl (drives issue, stall, flush, fwd_a_sel, fwd_b_sel, rf_write, rf_waddr)
interface hazard_ctrl_if #(parameter int FS_W = 2);

    logic            id_valid;
    logic [7:0]      id_instr;
    logic            ex_hold;
    logic            branch_taken;
    logic            issue;
    logic            stall;
    logic            flush;
    logic [FS_W-1:0] fwd_a_sel;
    logic [FS_W-1:0] fwd_b_sel;
    logic            rf_write;
    logic [1:0]      rf_waddr;

    modport master (
        output id_valid, id_instr, ex_hold, branch_taken,
        input  issue, stall, flush, fwd_a_sel, fwd_b_sel, rf_write, rf_waddr
    );

    modport slave (
        input  id_valid, id_instr, ex_hold, branch_taken,
        output issue, stall, flush, fwd_a_sel, fwd_b_sel, rf_write, rf_waddr
    );

endinterface

// File: rtl/hazard_ctrl_instr_decode.sv
// instr_decode: combinational wrapper around the package decode function
// instr in 8 : ID instruction word
// dec   out  : {writes, dst, rd_a, rd_b, src_a, src_b, is_load}
module instr_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [7:0] instr,
    output decode_t    dec
);

    assign dec = decode(instr);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-flight destination history, forwarding selects, load-use stall, branch flush, RF writeback
// clock in : rising-edge clock
// reset in : asynchronous, active-high
// bus       : hazard_ctrl_if.slave (ID inputs, issue/stall/flush, forwarding selects, RF write)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FWD_DEPTH   = 2,
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_DEPTH = 2,
    localparam int FS_W       = $clog2(FWD_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    decode_t          dec;
    hist_entry_t      hist [1:FWD_DEPTH];
    hist_entry_t      nxt  [1:FWD_DEPTH];
    logic [2:0]       flush_cnt;
    logic [FS_W-1:0]  sel_a, sel_b;
    logic             haz, live, flush, issue;

    instr_decode u_decode (
        .instr (bus.id_instr),
        .dec   (dec)
    );

    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz   = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (hist[k].valid && dec.rd_a && hist[k].dst == dec.src_a) sel_a = FS_W'(k);
            if (hist[k].valid && dec.rd_b && hist[k].dst == dec.src_b) sel_b = FS_W'(k);
            if (hist[k].valid && hist[k].is_load && k <= LOAD_STALL &&
                ((dec.rd_a && hist[k].dst == dec.src_a) || (dec.rd_b && hist[k].dst == dec.src_b)))
                haz = 1'b1;
        end
    end

    assign live       = ~reset & ~bus.ex_hold;
    assign flush      = live & (bus.branch_taken | flush_cnt != 3'd0);
    assign issue      = live & ~flush & bus.id_valid & ~haz;
    assign bus.flush  = flush;
    assign bus.issue  = issue;
    assign bus.stall  = live & ~flush & bus.id_valid & haz;

    // Non-writers enter as bubbles so they never forward or write back.
    always_comb begin
        nxt[1] = issue ? hist_entry_t'{valid: dec.writes, dst: dec.dst, is_load: dec.is_load} : '0;
        for (int k = 2; k <= FWD_DEPTH; k++) nxt[k] = hist[k-1];
    end

    // rf_write mirrors the oldest slot's occupant; with no RF write-through it stays forwardable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist          <= '{default: '0};
            flush_cnt     <= '0;
            bus.fwd_a_sel <= '0;
            bus.fwd_b_sel <= '0;
            bus.rf_write  <= 1'b0;
            bus.rf_waddr  <= '0;
        end else if (!bus.ex_hold) begin
            hist          <= nxt;
            flush_cnt     <= bus.branch_taken ? 3'(FLUSH_DEPTH - 1) : (flush_cnt != 3'd0 ? flush_cnt - 3'd1 : 3'd0);
            bus.fwd_a_sel <= issue ? sel_a : '0;
            bus.fwd_b_sel <= issue ? sel_b : '0;
            bus.rf_write  <= nxt[FWD_DEPTH].valid;
            bus.rf_waddr  <= nxt[FWD_DEPTH].dst;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (defaults and LOAD_STALL=0 instances)
module tb_hazard_ctrl;

    typedef struct {
        int         cyc;
        int         id;
        logic [6:0] m;
        logic       iss, stl, fls;
        logic [1:0] fa, fb;
        logic       rfw;
        logic [1:0] rfa;
    } exp_t;

    localparam logic [6:0] ALL = 7'h7f;
    localparam logic [6:0] CTL = 7'h07;
    localparam logic [6:0] SEL = 7'h18;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   step  = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    hazard_ctrl_if #(.FS_W(2)) b1 ();
    hazard_ctrl_if #(.FS_W(2)) b0 ();

    assign b0.id_valid     = b1.id_valid;
    assign b0.id_instr     = b1.id_instr;
    assign b0.ex_hold      = b1.ex_hold;
    assign b0.branch_taken = b1.branch_taken;

    hazard_ctrl dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
    hazard_ctrl #(.LOAD_STALL(0)) dut0 (.clock(clock), .reset(reset), .bus(b0.slave));

    task automatic drv(input logic v, input logic [7:0] i, input logic h, input logic br);
        @(posedge clock);
        #1;
        step++;
        b1.id_valid     = v;
        b1.id_instr     = i;
        b1.ex_hold      = h;
        b1.branch_taken = br;
    endtask

    task automatic ex(input int w, input logic [6:0] m, input logic iss, input logic stl, input logic fls,
                      input logic [1:0] fa, input logic [1:0] fb, input logic rfw, input logic [1:0] rfa);
        exp_t e;
        e = '{cyc: cyc, id: step, m: m, iss: iss, stl: stl, fls: fls, fa: fa, fb: fb, rfw: rfw, rfa: rfa};
        if (w == 1) q1.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic cf(input int w, input int id, input string nm, input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL dut%0d step%0d %s: got %0d want %0d", w, id, nm, act, want);
        end
    endtask

    task automatic check(input int w, input exp_t e, input logic iss, input logic stl, input logic fls,
                         input logic [1:0] fa, input logic [1:0] fb, input logic rfw, input logic [1:0] rfa);
        if (e.m[0]) cf(w, e.id, "issue", {1'b0, iss}, {1'b0, e.iss});
        if (e.m[1]) cf(w, e.id, "stall", {1'b0, stl}, {1'b0, e.stl});
        if (e.m[2]) cf(w, e.id, "flush", {1'b0, fls}, {1'b0, e.fls});
        if (e.m[3]) cf(w, e.id, "fwd_a_sel", fa, e.fa);
        if (e.m[4]) cf(w, e.id, "fwd_b_sel", fb, e.fb);
        if (e.m[5]) cf(w, e.id, "rf_write", {1'b0, rfw}, {1'b0, e.rfw});
        if (e.m[6]) cf(w, e.id, "rf_waddr", rfa, e.rfa);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clock);
        while (q1.size() != 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            check(1, e, b1.issue, b1.stall, b1.flush, b1.fwd_a_sel, b1.fwd_b_sel, b1.rf_write, b1.rf_waddr);
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clock);
        while (q0.size() != 0 && q0[0].cyc <= cyc) begin
            e = q0.pop_front();
            check(0, e, b0.issue, b0.stall, b0.flush, b0.fwd_a_sel, b0.fwd_b_sel, b0.rf_write, b0.rf_waddr);
        end
    end

    initial begin
        b1.id_valid     = 1'b0;
        b1.id_instr     = 8'h00;
        b1.ex_hold      = 1'b0;
        b1.branch_taken = 1'b0;
        // reset gates issue/flush even with live inputs
        drv(1, 8'h64, 0, 1); ex(1, ALL, 0,0,0, 0,0, 0,0); ex(0, ALL, 0,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); reset = 1'b0; ex(1, ALL, 0,0,0, 0,0, 0,0);
        // add r1,r2 then sub r1,r3: forward from slot 1
        drv(1, 8'h64, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h76, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 1,0, 1,1);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 1,1);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // load r2 then add r0,r2: one bubble with LOAD_STALL=1, none with 0
        drv(1, 8'hB0, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0); ex(0, CTL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 0,1,0, 0,0, 0,0); ex(0, CTL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 1,0,0, 0,0, 1,2); ex(0, 7'h1f, 1,0,0, 0,1, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,2, 0,0); ex(0, SEL, 0,0,0, 1,2, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 1,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // ori then add r1,r1: both operands from slot 1; ori writes r1 from slot 2
        drv(1, 8'h1F, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h54, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 1,1, 1,1);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 1,1);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // taken branch: two flush cycles, bubbles never write back
        drv(1, 8'h64, 0, 1); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(1, 8'h64, 0, 0); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // back-to-back branches reload the counter
        drv(0, 8'h00, 0, 1); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(0, 8'h00, 0, 1); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // load-use hazard inside a flush window: no stall
        drv(1, 8'hB0, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h24, 0, 1); ex(1, ALL, 0,0,1, 0,0, 0,0);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 0,0,1, 0,0, 1,2);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 1,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // ex_hold over a load-use stall; branch under hold ignored
        drv(1, 8'h64, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h90, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h24, 1, 0); ex(1, ALL, 0,0,0, 0,1, 1,1);
        drv(1, 8'h24, 1, 1); ex(1, ALL, 0,0,0, 0,1, 1,1);
        drv(1, 8'h24, 1, 0); ex(1, ALL, 0,0,0, 0,1, 1,1);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 0,1,0, 0,1, 1,1);
        drv(1, 8'h24, 0, 0); ex(1, ALL, 1,0,0, 0,0, 1,2);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,2, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 1,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        // reset mid-flush clears everything; no forwarding right after
        drv(1, 8'h64, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(1, 8'h76, 0, 0); ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 1); ex(1, ALL, 0,0,1, 1,0, 1,1);
        drv(1, 8'h64, 0, 0); reset = 1'b1; ex(1, ALL, 0,0,0, 0,0, 0,0);
        drv(1, 8'h76, 0, 0); reset = 1'b0; ex(1, ALL, 1,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0); ex(1, ALL, 0,0,0, 0,0, 0,0);
        drv(0, 8'h00, 0, 0);
        drv(0, 8'h00, 0, 0);
        @(negedge clock);
        #1;
        total++;
        if (q1.size() + q0.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries want 0", q1.size() + q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
